// File: rtl/grant_idx_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grant_idx_fifo_if
// Brief    : Grant sample input and indexed valid/ready output bundle.
// Revision : 1.0
// ============================================================================
interface grant_idx_fifo_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(N),
    parameter int LW    = $clog2(DEPTH) + 1
);
    logic          g_vld;
    logic [N-1:0]  grant;
    logic          g_idle;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [LW-1:0] level;
    logic          err_pulse;
    logic          err_sticky;
    logic          err_clr;
    logic          ovf_pulse;
    logic [7:0]    drop_cnt;

    // Master drives samples and consumes indices; slave is the FIFO block.
    modport master (
        output g_vld, grant, g_idle, out_ready, err_clr,
        input  out_valid, out_idx, level, err_pulse, err_sticky, ovf_pulse, drop_cnt
    );

    modport slave (
        input  g_vld, grant, g_idle, out_ready, err_clr,
        output out_valid, out_idx, level, err_pulse, err_sticky, ovf_pulse, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/grant_idx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : grant_idx_fifo
// Brief    : Validates one-hot grants, encodes them and queues indices.
// Revision : 1.0
// ============================================================================
module grant_idx_fifo #(
    parameter int N     = 8,
    parameter int IW    = $clog2(N),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    grant_idx_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [1:0]    state_q,      state_d;
    logic [LW-1:0] level_q,      level_d;
    logic [PW-1:0] wr_ptr_q,     wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,     rd_ptr_d;
    logic [IW-1:0] mem_q [DEPTH];
    logic [IW-1:0] mem_d [DEPTH];
    logic          err_pulse_q,  err_pulse_d;
    logic          err_sticky_q, err_sticky_d;
    logic          ovf_pulse_q,  ovf_pulse_d;
    logic [7:0]    drop_cnt_q,   drop_cnt_d;

    logic          w_onehot;
    logic          w_idle;
    logic          w_good;
    logic          w_bad;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [IW-1:0] w_idx;

    // Sample classification and encoding
    always_comb begin
        w_onehot = (bus.grant != '0) && ((bus.grant & (bus.grant - N'(1))) == '0);
        w_idle   = bus.g_vld && bus.g_idle && (bus.grant == '0);
        w_good   = bus.g_vld && !bus.g_idle && w_onehot;
        w_bad    = bus.g_vld && !w_idle && !w_good;
        w_idx    = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.grant[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_empty = (state_q == ST_EMPTY);
        w_full  = (state_q == ST_FULL);
        w_pop   = !w_empty && bus.out_ready;
        w_push  = w_good && (!w_full || w_pop);
        w_drop  = w_good && w_full && !w_pop;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = w_idx;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (w_pop && !w_push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Occupancy view follows the next level so it always agrees with level_q
    always_comb begin
        state_d = ST_PARTIAL;
        if (level_d == '0) begin
            state_d = ST_EMPTY;
        end else if (level_d == LW'(DEPTH)) begin
            state_d = ST_FULL;
        end
    end

    always_comb begin
        err_pulse_d  = w_bad;
        err_sticky_d = err_sticky_q;
        if (w_bad) begin
            err_sticky_d = 1'b1;
        end else if (bus.err_clr) begin
            err_sticky_d = 1'b0;
        end
        ovf_pulse_d = w_drop;
        drop_cnt_d  = drop_cnt_q;
        if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            level_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            ovf_pulse_q  <= 1'b0;
            drop_cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            ovf_pulse_q  <= ovf_pulse_d;
            drop_cnt_q   <= drop_cnt_d;
            mem_q        <= mem_d;
        end
    end

    // Index is forced to zero while empty so stale entries never leak out
    assign bus.out_valid  = !w_empty;
    assign bus.out_idx    = w_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.level      = level_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.ovf_pulse  = ovf_pulse_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_grant_idx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_grant_idx_fifo
// Brief    : Directed self-checking bench for grant_idx_fifo.
// Revision : 1.0
// ============================================================================
module tb_grant_idx_fifo;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    grant_idx_fifo_if #(.N(8), .DEPTH(4)) bus ();

    grant_idx_fifo #(.N(8), .IW(3), .DEPTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [7:0] g, input logic idle);
        bus.g_vld  = 1'b1;
        bus.grant  = g;
        bus.g_idle = idle;
        step();
        bus.g_vld  = 1'b0;
        bus.grant  = 8'h00;
        bus.g_idle = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, "_idx"},    32'(bus.out_idx),    32'd0);
        chk({tag, "_level"},  32'(bus.level),      32'd0);
        chk({tag, "_errp"},   32'(bus.err_pulse),  32'd0);
        chk({tag, "_errs"},   32'(bus.err_sticky), 32'd0);
        chk({tag, "_ovf"},    32'(bus.ovf_pulse),  32'd0);
        chk({tag, "_drop"},   32'(bus.drop_cnt),   32'd0);
    endtask

    task automatic fill_four();
        sample(8'h01, 1'b0);
        sample(8'h02, 1'b0);
        sample(8'h04, 1'b0);
        sample(8'h08, 1'b0);
        chk("fill_level", 32'(bus.level), 32'd4);
    endtask

    initial begin
        logic [2:0] exp_idx [4];
        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        bus.g_vld = 1'b0;
        bus.grant = 8'h00;
        bus.g_idle = 1'b0;
        bus.out_ready = 1'b0;
        bus.err_clr = 1'b0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single grant, latency one, then pop
        sample(8'h20, 1'b0);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_idx",   32'(bus.out_idx),   32'd5);
        chk("t1_level", 32'(bus.level),     32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t1_valid_after", 32'(bus.out_valid), 32'd0);
        chk("t1_level_after", 32'(bus.level),     32'd0);

        // 2: fill, overflow, drain in order
        fill_four();
        sample(8'h80, 1'b0);
        chk("t2_ovf",   32'(bus.ovf_pulse), 32'd1);
        chk("t2_drop",  32'(bus.drop_cnt),  32'd1);
        chk("t2_level", 32'(bus.level),     32'd4);
        chk("t2_idx_hold", 32'(bus.out_idx), 32'd0);
        step();
        chk("t2_ovf_low", 32'(bus.ovf_pulse), 32'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_drain_idx%0d", i), 32'(bus.out_idx), 32'(i));
            chk($sformatf("t2_drain_lvl%0d", i), 32'(bus.level),   32'(4 - i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t2_empty", 32'(bus.out_valid), 32'd0);

        // 3: push and pop together while full
        fill_four();
        bus.out_ready = 1'b1;
        sample(8'h40, 1'b0);
        chk("t3_level", 32'(bus.level),     32'd4);
        chk("t3_ovf",   32'(bus.ovf_pulse), 32'd0);
        chk("t3_drop",  32'(bus.drop_cnt),  32'd1);
        exp_idx[0] = 3'd1;
        exp_idx[1] = 3'd2;
        exp_idx[2] = 3'd3;
        exp_idx[3] = 3'd6;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_drain_idx%0d", i), 32'(bus.out_idx), 32'(exp_idx[i]));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t3_empty", 32'(bus.out_valid), 32'd0);

        // 4: malformed samples back to back, then clear behaviour
        sample(8'h03, 1'b0);
        chk("t4_errp_a", 32'(bus.err_pulse),  32'd1);
        chk("t4_errs_a", 32'(bus.err_sticky), 32'd1);
        sample(8'h00, 1'b0);
        chk("t4_errp_b", 32'(bus.err_pulse),  32'd1);
        sample(8'h10, 1'b1);
        chk("t4_errp_c", 32'(bus.err_pulse),  32'd1);
        chk("t4_level",  32'(bus.level),      32'd0);
        step();
        chk("t4_errp_low",  32'(bus.err_pulse),  32'd0);
        chk("t4_errs_hold", 32'(bus.err_sticky), 32'd1);
        bus.err_clr = 1'b1;
        step();
        chk("t4_errs_clr", 32'(bus.err_sticky), 32'd0);
        sample(8'h05, 1'b0);
        bus.err_clr = 1'b0;
        chk("t4_errs_setwins", 32'(bus.err_sticky), 32'd1);
        chk("t4_errp_d",       32'(bus.err_pulse),  32'd1);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;

        // 5: idle sample and unstrobed garbage are ignored
        sample(8'h00, 1'b1);
        chk("t5_level", 32'(bus.level),     32'd0);
        chk("t5_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_errp",  32'(bus.err_pulse), 32'd0);
        chk("t5_ovf",   32'(bus.ovf_pulse), 32'd0);
        bus.grant = 8'hFF;
        step();
        bus.grant = 8'h00;
        chk("t5_nv_level", 32'(bus.level),     32'd0);
        chk("t5_nv_errp",  32'(bus.err_pulse), 32'd0);
        chk("t5_nv_errs",  32'(bus.err_sticky), 32'd0);

        // 6: saturating drop counter and asynchronous reset
        fill_four();
        bus.g_vld = 1'b1;
        bus.grant = 8'h80;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        chk("t6_drop_sat", 32'(bus.drop_cnt),  32'd255);
        chk("t6_ovf",      32'(bus.ovf_pulse), 32'd1);
        chk("t6_level",    32'(bus.level),     32'd4);
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_async");
        bus.g_vld = 1'b0;
        bus.grant = 8'h00;
        step();
        chk_zero("t6_held");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
